// File: rtl/wb_mem_slave.sv
// -----------------------------------------------------------------------------
// wb_mem_slave
//   Wishbone classic-cycle responder backed by a word-addressed, byte-enabled
//   SRAM. A request is captured in IDLE, optionally held for WAIT_CYCLES idle
//   cycles, then answered with a single-cycle ack (in range) or err (out of
//   range) in RESP. Serves cache line fills and dirty-line write-backs.
//
//   Handshake: a request is offered when wb_cyc_i & wb_stb_i are high on a
//   clock edge while the responder is IDLE; it is taken on that edge. The
//   transfer completes in the single cycle wb_ack_o or wb_err_o is high.
//   wb_cyc_i must remain high until that cycle ends; dropping it earlier
//   aborts the transfer with no response and no write. wb_stb_i may drop
//   after capture without effect.
//
// Ports
//   clk, rstn_i   clock, asynchronous active-low reset
//   wb_cyc_i      bus cycle active
//   wb_stb_i      request strobe
//   wb_we_i       1 = write, 0 = read
//   wb_sel_i      byte lane enables (bit n -> data[8n+7:8n])
//   wb_adr_i      byte address
//   wb_dat_i      write data
//   wb_dat_o      read data, registered on entry to RESP, held until next RESP
//   wb_ack_o      transfer complete (one cycle)
//   wb_err_o      address fault (one cycle)
//   busy_o        transaction in progress (WAIT or RESP)
// -----------------------------------------------------------------------------
module wb_mem_slave #(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        busy_o
);

   localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
   // One bit wider than the address so MEM_WORDS*4 cannot overflow.
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        dat_q;
   logic [3:0]         sel_q;
   logic               we_q;
   logic               hit_q;
   logic [31:0]        rdat_q;
   logic [31:0]        mem [MEM_WORDS];

   logic               req;
   logic               capture;
   logic [31:0]        offset;
   logic               hit_in;
   logic [IDX_W-1:0]   idx_in;
   logic               enter_resp;
   logic [IDX_W-1:0]   rd_idx;
   logic               rd_we;
   logic               rd_hit;
   logic               mem_we;

   assign req     = wb_cyc_i & wb_stb_i;
   assign capture = (state_q == IDLE) && req;

   // Address decode of the incoming request. A wrapped subtraction is fine
   // because the lower-bound compare rejects addresses below BASE_ADDR.
   assign offset = wb_adr_i - BASE_ADDR;
   assign hit_in = (wb_adr_i >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
   assign idx_in = offset[IDX_W+1:2];

   // With WAIT_CYCLES = 0 RESP is entered on the capture edge itself, so the
   // read path must look at the live bus rather than the capture registers.
   assign rd_idx = (state_q == IDLE) ? idx_in  : idx_q;
   assign rd_we  = (state_q == IDLE) ? wb_we_i : we_q;
   assign rd_hit = (state_q == IDLE) ? hit_in  : hit_q;

   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // Writes commit on the edge that leaves RESP, only if the cycle was not
   // aborted in the response cycle.
   assign mem_we = (state_q == RESP) && wb_cyc_i && we_q && hit_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
            end
         end
         // RESP always returns to IDLE, which guarantees an idle cycle
         // between consecutive transfers.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_o   = (state_q != IDLE);
      wb_ack_o = (state_q == RESP) && wb_cyc_i && hit_q;
      wb_err_o = (state_q == RESP) && wb_cyc_i && !hit_q;
   end

   assign wb_dat_o = rdat_q;

   // ---------------- capture, wait counter, read data ----------------
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q  <= 4'd0;
         idx_q  <= '0;
         dat_q  <= 32'h0;
         sel_q  <= 4'h0;
         we_q   <= 1'b0;
         hit_q  <= 1'b0;
         rdat_q <= 32'h0;
      end else begin
         if (capture) begin
            idx_q <= idx_in;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            we_q  <= wb_we_i;
            hit_q <= hit_in;
            cnt_q <= WAIT_LOAD;
         end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (enter_resp) begin
            if (!rd_hit) begin
               rdat_q <= 32'h0;
            end else if (!rd_we) begin
               rdat_q <= mem[rd_idx];
            end
         end
      end
   end

   // ---------------- storage (not reset) ----------------
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) begin
               mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_slave
//   Two responders share one bus: u_dut0 with one wait state, u_dut1 with
//   three. Each has its own cyc/stb so only one is addressed at a time.
//   A word-array model per responder predicts read data; latency, ack/err
//   choice and response width are predicted from the transfer rules.
// -----------------------------------------------------------------------------
module tb_wb_mem_slave;

   localparam int WC0 = 1;
   localparam int WC1 = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [1:0]  cyc, stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic [1:0]  ack, err, busy;
   logic [31:0] rdat0, rdat1;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   logic [31:0] mdl [2][1024];
   logic [31:0] last_dat [2];

   wb_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(WC0), .BASE_ADDR(32'h0)) u_dut0 (
      .clk(clk), .rstn_i(rstn),
      .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat0),
      .wb_ack_o(ack[0]), .wb_err_o(err[0]), .busy_o(busy[0])
   );

   wb_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(WC1), .BASE_ADDR(32'h0)) u_dut1 (
      .clk(clk), .rstn_i(rstn),
      .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat1),
      .wb_ack_o(ack[1]), .wb_err_o(err[1]), .busy_o(busy[1])
   );

   // ---------------- helpers ----------------
   function automatic int wc(input int d);
      return (d == 1) ? WC1 : WC0;
   endfunction

   function automatic logic [31:0] rdat_of(input int d);
      return (d == 1) ? rdat1 : rdat0;
   endfunction

   // Byte-lane merge: lane n of the result comes from nw when s[n] is set.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver: one complete transfer ----------------
   task automatic xfer(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] v, input bit drop_stb);
      logic        hit;
      logic [31:0] e;
      int          n;
      bit          got;
      hit = (a < 32'h0000_1000);
      @(negedge clk);
      chk("idle_before", {31'b0, busy[d]}, 32'd0);
      we = w; adr = a; sel = s; wdat = v;
      cyc[d] = 1'b1; stb[d] = 1'b1;
      if (!hit)      e = 32'h0;
      else if (!w)   e = mdl[d][a[11:2]];
      else           e = last_dat[d];
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (drop_stb) stb[d] = 1'b0;
      // Bus contents after capture must not matter.
      adr = $urandom; wdat = $urandom; sel = 4'($urandom); we = 1'($urandom);
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (ack[d] | err[d]) got = 1'b1;
         else chk("busy_wait", {31'b0, busy[d]}, 32'd1);
      end
      chk("resp_seen", {31'b0, got}, 32'd1);
      chk("latency", n, wc(d) + 1);
      chk("ack", {31'b0, ack[d]}, {31'b0, hit});
      chk("err", {31'b0, err[d]}, {31'b0, !hit});
      e = exp_q.pop_front();
      chk("rdat", rdat_of(d), e);
      last_dat[d] = e;
      @(posedge clk); #1;
      cyc[d] = 1'b0; stb[d] = 1'b0;
      if (w && hit) mdl[d][a[11:2]] = merge(mdl[d][a[11:2]], v, s);
      @(negedge clk);
      chk("resp_width", {31'b0, ack[d] | err[d]}, 32'd0);
      chk("busy_after", {31'b0, busy[d]}, 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] a, v;
      int d;
      rstn = 1'b0; cyc = 2'b00; stb = 2'b00; we = 1'b0; sel = 4'h0;
      adr = 32'h0; wdat = 32'h0;
      last_dat[0] = 32'h0; last_dat[1] = 32'h0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ack", {31'b0, ack[i]}, 32'd0);
         chk("rst_err", {31'b0, err[i]}, 32'd0);
         chk("rst_busy", {31'b0, busy[i]}, 32'd0);
         chk("rst_rdat", rdat_of(i), 32'h0);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // Preload a 64-word window in both memories.
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 64; w++)
            xfer(i, 1'b1, 32'(w * 4), 4'hF, $urandom, 1'b0);

      // Single write / read.
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
      chk("wr_rd_value", rdat0, 32'hDEAD_BEEF);

      // Byte enables, including an empty mask; low address bits ignored.
      xfer(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0);
      xfer(0, 1'b1, 32'h22, 4'b0101, 32'hAABB_CCDD, 1'b0);
      xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
      chk("byte_en_value", rdat0, 32'h11BB_33DD);
      xfer(0, 1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, 1'b0);
      xfer(0, 1'b0, 32'h21, 4'hF, 32'h0, 1'b0);
      chk("sel_zero_value", rdat0, 32'h11BB_33DD);

      // Line fill.
      for (int w = 0; w < 8; w++)
         xfer(0, 1'b1, 32'h40 + 32'(w * 4), 4'hF, 32'hC0DE_0000 + 32'(w), 1'b0);
      for (int w = 0; w < 8; w++)
         xfer(0, 1'b0, 32'h40 + 32'(w * 4), 4'hF, 32'h0, 1'b0);
      chk("line_last", rdat0, 32'hC0DE_0007);

      // Out of range.
      xfer(0, 1'b1, 32'h1000, 4'hF, 32'h5555_AAAA, 1'b0);
      xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
      xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0);
      xfer(1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 1'b0);

      // Abort a write on the three-wait-state responder.
      @(negedge clk);
      we = 1'b1; adr = 32'h30; sel = 4'hF; wdat = 32'hCAFE_F00D;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb[1] = 1'b0;
      @(negedge clk);
      chk("abort_no_resp0", {31'b0, ack[1] | err[1]}, 32'd0);
      chk("abort_busy0", {31'b0, busy[1]}, 32'd1);
      @(negedge clk);
      chk("abort_idle", {31'b0, busy[1]}, 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_resp", {31'b0, ack[1] | err[1]}, 32'd0);
      end
      xfer(1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0);

      // Asynchronous reset in the middle of a wait.
      xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      we = 1'b0; adr = 32'h24; cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("pre_reset_busy", {31'b0, busy[1]}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("arst_ack", {31'b0, ack[1]}, 32'd0);
      chk("arst_err", {31'b0, err[1]}, 32'd0);
      chk("arst_busy", {31'b0, busy[1]}, 32'd0);
      chk("arst_rdat1", rdat1, 32'h0);
      chk("arst_rdat0", rdat0, 32'h0);
      last_dat[0] = 32'h0; last_dat[1] = 32'h0;
      cyc[1] = 1'b0; stb[1] = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      xfer(1, 1'b0, 32'h24, 4'hF, 32'h0, 1'b0);
      xfer(0, 1'b1, 32'h24, 4'hF, 32'h0BAD_F00D, 1'b0);
      xfer(0, 1'b0, 32'h24, 4'hF, 32'h0, 1'b0);

      // Random traffic against the model.
      for (int k = 0; k < 150; k++) begin
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
            if (a < 32'h1000) a = a + 32'h1000;
         end else begin
            a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
         end
         v = $urandom;
         xfer(d, 1'($urandom), a, 4'($urandom), v, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
